// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, ALU codes,
// mux selects and the controller state type.
package multicycle_pkg;

  localparam int unsigned OP_R    = 0;
  localparam int unsigned OP_ADDI = 1;
  localparam int unsigned OP_ANDI = 2;
  localparam int unsigned OP_ORI  = 3;
  localparam int unsigned OP_SUBI = 4;
  localparam int unsigned OP_LHW  = 7;
  localparam int unsigned OP_SHW  = 8;
  localparam int unsigned OP_BEQ  = 9;
  localparam int unsigned OP_BNE  = 10;
  localparam int unsigned OP_BLT  = 11;
  localparam int unsigned OP_BGT  = 12;
  localparam int unsigned OP_JUMP = 15;

  localparam int unsigned ALU_FUNCT = 0;
  localparam int unsigned ALU_ADD   = 1;
  localparam int unsigned ALU_AND   = 2;
  localparam int unsigned ALU_OR    = 3;
  localparam int unsigned ALU_SUB   = 4;
  localparam int unsigned ALU_CMP   = 5;

  localparam logic [1:0] SRCB_RT  = 2'd0;
  localparam logic [1:0] SRCB_ONE = 2'd1;
  localparam logic [1:0] SRCB_IMM = 2'd2;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR,
    WB_ALU, WB_MEM, BRANCH, JUMP
  } state_t;

endpackage

// File: rtl/multicycle_control_retire_counter.sv
// Retired-instruction counter: CNT_W-bit enable counter, wraps naturally.
module retire_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count <= '0;
    else if (en)  count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle controller: registered state machine driving datapath selects,
// memory handshake, illegal-opcode flag and retired-instruction count.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned ALUOP_W  = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                mem_read,
  output logic                mem_write,
  output logic                i_or_d,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic [3:0]          branch_en,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                illegal,
  output logic [CNT_W-1:0]    retired,
  output logic [3:0]          state
);

  localparam logic [OPCODE_W-1:0] C_R    = OPCODE_W'(OP_R);
  localparam logic [OPCODE_W-1:0] C_ADDI = OPCODE_W'(OP_ADDI);
  localparam logic [OPCODE_W-1:0] C_ANDI = OPCODE_W'(OP_ANDI);
  localparam logic [OPCODE_W-1:0] C_ORI  = OPCODE_W'(OP_ORI);
  localparam logic [OPCODE_W-1:0] C_SUBI = OPCODE_W'(OP_SUBI);
  localparam logic [OPCODE_W-1:0] C_LHW  = OPCODE_W'(OP_LHW);
  localparam logic [OPCODE_W-1:0] C_SHW  = OPCODE_W'(OP_SHW);
  localparam logic [OPCODE_W-1:0] C_BEQ  = OPCODE_W'(OP_BEQ);
  localparam logic [OPCODE_W-1:0] C_BNE  = OPCODE_W'(OP_BNE);
  localparam logic [OPCODE_W-1:0] C_BLT  = OPCODE_W'(OP_BLT);
  localparam logic [OPCODE_W-1:0] C_BGT  = OPCODE_W'(OP_BGT);
  localparam logic [OPCODE_W-1:0] C_JUMP = OPCODE_W'(OP_JUMP);

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] op_q;
  logic                retire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) op_q <= opcode;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_ALU;
    branch_en  = '0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op     = ALUOP_W'(ALU_FUNCT);
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    retire     = 1'b0;

    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_ONE;
        alu_op    = ALUOP_W'(ALU_ADD);
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_W'(ALU_ADD);
        case (opcode)
          C_R:                           state_d = EXEC_R;
          C_ADDI, C_ANDI, C_ORI, C_SUBI: state_d = EXEC_I;
          C_LHW, C_SHW:                  state_d = ADDR;
          C_BEQ, C_BNE, C_BLT, C_BGT:    state_d = BRANCH;
          C_JUMP:                        state_d = JUMP;
          default: begin
            illegal = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        state_d   = WB_ALU;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        case (op_q)
          C_ANDI:  alu_op = ALUOP_W'(ALU_AND);
          C_ORI:   alu_op = ALUOP_W'(ALU_OR);
          C_SUBI:  alu_op = ALUOP_W'(ALU_SUB);
          default: alu_op = ALUOP_W'(ALU_ADD);
        endcase
        state_d = WB_ALU;
      end
      ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_W'(ALU_ADD);
        state_d   = (op_q == C_SHW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = WB_MEM;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      WB_ALU: begin
        reg_write = 1'b1;
        reg_dst   = (op_q == C_R);
        retire    = 1'b1;
        state_d   = FETCH;
      end
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_W'(ALU_CMP);
        pc_src    = PC_BRANCH;
        case (op_q)
          C_BEQ:   branch_en = 4'b0001;
          C_BNE:   branch_en = 4'b0010;
          C_BLT:   branch_en = 4'b0100;
          default: branch_en = 4'b1000;
        endcase
        retire  = 1'b1;
        state_d = FETCH;
      end
      JUMP: begin
        pc_write = 1'b1;
        pc_src   = PC_JUMP;
        retire   = 1'b1;
        state_d  = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // Reset forces FETCH, whose request would otherwise be visible while reset is held.
    if (!reset_n) begin
      mem_read = 1'b0;
      ir_write = 1'b0;
      pc_write = 1'b0;
    end
  end

  assign state = state_q;

  retire_counter #(.CNT_W(CNT_W)) u_retire (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (retire),
    .count   (retired)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-instruction expected cycle traces
// built from the instruction class, checked every cycle on two DUT widths.
module tb_multicycle_control;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2,
                         S_EXEC_I = 4'd3, S_ADDR = 4'd4, S_MEM_RD = 4'd5,
                         S_MEM_WR = 4'd6, S_WB_ALU = 4'd7, S_WB_MEM = 4'd8,
                         S_BRANCH = 4'd9, S_JUMP = 4'd10;
  localparam logic [3:0] NOP = 4'hE;  // undefined opcode parked outside DECODE

  typedef struct packed {
    logic [3:0]  st;
    logic        mem_read, mem_write, i_or_d, ir_write, pc_write;
    logic [1:0]  pc_src;
    logic [3:0]  branch_en;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_op;
    logic        reg_write, reg_dst, mem_to_reg, illegal;
    logic [15:0] retired;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset_n, mem_ready;
  logic [3:0]  opcode;

  logic        mem_read, mem_write, i_or_d, ir_write, pc_write;
  logic [1:0]  pc_src, alu_src_b;
  logic [3:0]  branch_en, state;
  logic        alu_src_a, reg_write, reg_dst, mem_to_reg, illegal;
  logic [2:0]  alu_op;
  logic [15:0] retired;

  logic        mem_read4, mem_write4, i_or_d4, ir_write4, pc_write4;
  logic [1:0]  pc_src4, alu_src_b4;
  logic [3:0]  branch_en4, state4;
  logic        alu_src_a4, reg_write4, reg_dst4, mem_to_reg4, illegal4;
  logic [2:0]  alu_op4;
  logic [3:0]  retired4;

  int unsigned vectors = 0, miscompares = 0;
  logic [15:0] cnt = '0;
  obs_t        exp_q[$];

  always #5 clk = ~clk;

  multicycle_control #(.OPCODE_W(4), .ALUOP_W(3), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .branch_en(branch_en), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .illegal(illegal), .retired(retired), .state(state)
  );

  multicycle_control #(.OPCODE_W(4), .ALUOP_W(3), .CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .mem_read(mem_read4), .mem_write(mem_write4), .i_or_d(i_or_d4),
    .ir_write(ir_write4), .pc_write(pc_write4), .pc_src(pc_src4),
    .branch_en(branch_en4), .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4),
    .alu_op(alu_op4), .reg_write(reg_write4), .reg_dst(reg_dst4),
    .mem_to_reg(mem_to_reg4), .illegal(illegal4), .retired(retired4), .state(state4)
  );

  always @(negedge clk) begin
    obs_t e, a, e4, a4;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = '{st:state, mem_read:mem_read, mem_write:mem_write, i_or_d:i_or_d,
            ir_write:ir_write, pc_write:pc_write, pc_src:pc_src,
            branch_en:branch_en, alu_src_a:alu_src_a, alu_src_b:alu_src_b,
            alu_op:alu_op, reg_write:reg_write, reg_dst:reg_dst,
            mem_to_reg:mem_to_reg, illegal:illegal, retired:retired};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL cycle16 t=%0t state=%0d got=%h expected=%h", $time, e.st, a, e);
      end
      e4 = e;
      e4.retired = {12'd0, e.retired[3:0]};
      a4 = '{st:state4, mem_read:mem_read4, mem_write:mem_write4, i_or_d:i_or_d4,
             ir_write:ir_write4, pc_write:pc_write4, pc_src:pc_src4,
             branch_en:branch_en4, alu_src_a:alu_src_a4, alu_src_b:alu_src_b4,
             alu_op:alu_op4, reg_write:reg_write4, reg_dst:reg_dst4,
             mem_to_reg:mem_to_reg4, illegal:illegal4, retired:{12'd0, retired4}};
      vectors++;
      if (a4 !== e4) begin
        miscompares++;
        $display("FAIL cycle4 t=%0t state=%0d got=%h expected=%h", $time, e.st, a4, e4);
      end
    end
  end

  task automatic lit(input string name, input logic [15:0] got, input logic [15:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  function automatic obs_t rec(input logic [3:0] st);
    obs_t e;
    e = '0;
    e.st = st;
    return e;
  endfunction

  // One clock cycle: drive inputs just after the edge, record what must be seen.
  task automatic cyc(input logic ready, input logic [3:0] opc, input obs_t e);
    @(posedge clk);
    #1;
    mem_ready = ready;
    opcode    = opc;
    e.retired = cnt;
    exp_q.push_back(e);
  endtask

  task automatic stall(input int n);
    obs_t e;
    for (int i = 0; i < n; i++) begin
      e = rec(S_FETCH); e.mem_read = 1; e.alu_src_b = 1; e.alu_op = 1;
      cyc(1'b0, NOP, e);
    end
  endtask

  task automatic run_instr(input logic [3:0] op, input int fw, input int mw);
    obs_t e;
    logic rnd;
    stall(fw);
    e = rec(S_FETCH); e.mem_read = 1; e.alu_src_b = 1; e.alu_op = 1;
    e.ir_write = 1; e.pc_write = 1;
    cyc(1'b1, NOP, e);
    rnd = 1'($urandom_range(0, 1));
    e = rec(S_DECODE); e.alu_src_b = 2; e.alu_op = 1;
    e.illegal = !(op inside {0, 1, 2, 3, 4, 7, 8, 9, 10, 11, 12, 15});
    cyc(rnd, op, e);
    rnd = 1'($urandom_range(0, 1));
    if (op == 0) begin
      e = rec(S_EXEC_R); e.alu_src_a = 1; cyc(rnd, NOP, e);
      e = rec(S_WB_ALU); e.reg_write = 1; e.reg_dst = 1; cyc(rnd, NOP, e);
      cnt++;
    end else if (op inside {1, 2, 3, 4}) begin
      e = rec(S_EXEC_I); e.alu_src_a = 1; e.alu_src_b = 2; e.alu_op = op[2:0];
      cyc(rnd, NOP, e);
      e = rec(S_WB_ALU); e.reg_write = 1; cyc(rnd, NOP, e);
      cnt++;
    end else if (op == 7 || op == 8) begin
      e = rec(S_ADDR); e.alu_src_a = 1; e.alu_src_b = 2; e.alu_op = 1;
      cyc(rnd, NOP, e);
      for (int i = 0; i <= mw; i++) begin
        e = rec(op == 7 ? S_MEM_RD : S_MEM_WR); e.i_or_d = 1;
        if (op == 7) e.mem_read = 1; else e.mem_write = 1;
        cyc(i == mw, NOP, e);
      end
      if (op == 7) begin
        e = rec(S_WB_MEM); e.reg_write = 1; e.mem_to_reg = 1; cyc(rnd, NOP, e);
      end
      cnt++;
    end else if (op inside {9, 10, 11, 12}) begin
      e = rec(S_BRANCH); e.alu_src_a = 1; e.alu_op = 5; e.pc_src = 1;
      e.branch_en = 4'(1 << (op - 9));
      cyc(rnd, NOP, e);
      cnt++;
    end else if (op == 15) begin
      e = rec(S_JUMP); e.pc_write = 1; e.pc_src = 2; cyc(rnd, NOP, e);
      cnt++;
    end
  endtask

  initial begin
    obs_t e;
    reset_n = 1'b0; mem_ready = 1'b0; opcode = NOP;
    #7;
    lit("reset_state", 16'(state), 16'd0);
    lit("reset_retired", retired, 16'd0);
    lit("reset_mem_read", 16'(mem_read), 16'd0);
    #5 reset_n = 1'b1;

    run_instr(4'd1, 0, 0);
    stall(1);
    lit("addi_retired", retired, 16'd1);
    run_instr(4'd7, 0, 2);
    run_instr(4'd8, 0, 0);
    run_instr(4'd9, 0, 0);
    run_instr(4'd10, 0, 0);
    run_instr(4'd11, 0, 0);
    run_instr(4'd12, 0, 0);
    run_instr(4'd15, 0, 0);
    run_instr(4'd5, 0, 0);
    run_instr(4'd0, 0, 0);
    run_instr(4'd2, 0, 0);
    run_instr(4'd3, 0, 0);
    run_instr(4'd4, 0, 0);
    run_instr(4'd7, 1, 0);
    run_instr(4'd8, 0, 1);
    run_instr(4'd1, 2, 0);
    stall(1);
    lit("retired4_at_max", 16'(retired4), 16'd15);
    run_instr(4'd15, 0, 0);
    stall(1);
    lit("retired4_wrapped", 16'(retired4), 16'd0);
    lit("retired16_count", retired, 16'd16);
    run_instr(4'd6, 0, 0);
    run_instr(4'd14, 0, 0);

    // Store interrupted by reset while waiting on memory.
    e = rec(S_FETCH); e.mem_read = 1; e.alu_src_b = 1; e.alu_op = 1;
    e.ir_write = 1; e.pc_write = 1;
    cyc(1'b1, NOP, e);
    e = rec(S_DECODE); e.alu_src_b = 2; e.alu_op = 1; cyc(1'b0, 4'd8, e);
    e = rec(S_ADDR); e.alu_src_a = 1; e.alu_src_b = 2; e.alu_op = 1; cyc(1'b1, NOP, e);
    e = rec(S_MEM_WR); e.mem_write = 1; e.i_or_d = 1; cyc(1'b0, NOP, e);
    @(negedge clk);
    #1;
    lit("memwr_before_reset", 16'(mem_write), 16'd1);
    reset_n = 1'b0;
    #1;
    lit("memwr_async_drop", 16'(mem_write), 16'd0);
    lit("reset_mid_state", 16'(state), 16'd0);
    lit("reset_mid_retired", retired, 16'd0);
    lit("reset_mid_mem_read", 16'(mem_read), 16'd0);
    cnt = '0;
    #1 reset_n = 1'b1;
    run_instr(4'd1, 0, 0);
    stall(1);
    lit("post_reset_retired", retired, 16'd1);
    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
